// File: rtl/cpu_fetch_decode_if.sv
// Shared opcode/operation definitions and the fetch/decode bus bundle.
// master = fetch/decode stage (drives memory reads and ALU issue); slave = memory + ALU.
package cpu_pkg;
  typedef enum logic [2:0] {
    Operation_ADD  = 3'd0,
    Operation_SUB  = 3'd1,
    Operation_NOR  = 3'd2,
    Operation_NAND = 3'd3,
    Operation_XOR  = 3'd4,
    Operation_XNOR = 3'd5
  } Operation;

  localparam logic [7:0] OP_HALT   = 8'h00;
  localparam logic [7:0] OP_ADD    = 8'h40;
  localparam logic [7:0] OP_SUB    = 8'h41;
  localparam logic [7:0] OP_ADD_C  = 8'h42;
  localparam logic [7:0] OP_SUB_C  = 8'h43;
  localparam logic [7:0] OP_ADD_I  = 8'h44;
  localparam logic [7:0] OP_SUB_I  = 8'h45;
  localparam logic [7:0] OP_ADD_IC = 8'h46;
  localparam logic [7:0] OP_SUB_IC = 8'h47;
  localparam logic [7:0] OP_NOR    = 8'h80;
  localparam logic [7:0] OP_NAND   = 8'h81;
  localparam logic [7:0] OP_XOR    = 8'h82;
  localparam logic [7:0] OP_XNOR   = 8'h83;
  localparam logic [7:0] OP_NOR_I  = 8'h84;
  localparam logic [7:0] OP_NAND_I = 8'h85;
  localparam logic [7:0] OP_XOR_I  = 8'h86;
  localparam logic [7:0] OP_XNOR_I = 8'h87;
endpackage

interface cpu_fetch_decode_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [8+DATA_W-1:0]   mem_rdata;
  logic                  out_valid;
  logic                  out_ready;
  cpu_pkg::Operation     out_op;
  logic                  out_use_imm;
  logic                  out_use_carry;
  logic [DATA_W-1:0]     out_operand;

  modport master (
    output mem_rd, mem_addr,
    input  mem_rdata,
    output out_valid, out_op, out_use_imm, out_use_carry, out_operand,
    input  out_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_rdata,
    input  out_valid, out_op, out_use_imm, out_use_carry, out_operand,
    output out_ready
  );
endinterface

// File: rtl/cpu_fetch_decode.sv
// Fetch/decode stage: FETCH -> WAIT -> ISSUE, out_valid 2 cycles after the fetch, one instr per 3+ cycles.
// Backpressure: ISSUE holds all out_* registered and stable until out_ready; stops on HALT or illegal opcode.
module cpu_fetch_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    pc_start_i,
  cpu_fetch_decode_if.master   bus,
  output logic                 busy_o,
  output logic                 halted_o,
  output logic                 illegal_o,
  output logic [ADDR_W-1:0]    illegal_pc_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_HALTED, S_ERROR
  } state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                mem_rd_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                out_valid_q;
  Operation            out_op_q;
  logic                out_imm_q, out_carry_q;
  logic [DATA_W-1:0]   out_operand_q;
  logic                halted_q, illegal_q;
  logic [ADDR_W-1:0]   illegal_pc_q;

  logic [7:0]          opc;
  logic                dec_legal;
  Operation            dec_op;
  logic                dec_imm, dec_carry;

  assign pc_d = pc_q + ADDR_W'(1);

  always_comb begin
    opc       = bus.mem_rdata[DATA_W +: 8];
    dec_legal = 1'b0;
    dec_op    = Operation_ADD;
    dec_imm   = opc[2];
    dec_carry = 1'b0;
    if (opc[5:3] == 3'b000) begin
      case (opc[7:6])
        2'b01: begin
          dec_legal = 1'b1;
          dec_op    = opc[0] ? Operation_SUB : Operation_ADD;
          dec_carry = opc[1];
        end
        2'b10: begin
          dec_legal = 1'b1;
          case (opc[1:0])
            2'b00:   dec_op = Operation_NOR;
            2'b01:   dec_op = Operation_NAND;
            2'b10:   dec_op = Operation_XOR;
            default: dec_op = Operation_XNOR;
          endcase
        end
        default: dec_legal = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      out_valid_q   <= 1'b0;
      out_op_q      <= Operation_ADD;
      out_imm_q     <= 1'b0;
      out_carry_q   <= 1'b0;
      out_operand_q <= '0;
      halted_q      <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_pc_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_HALTED, S_ERROR: begin
          if (start_i) begin
            state_q      <= S_FETCH;
            pc_q         <= pc_start_i;
            mem_rd_q     <= 1'b1;
            mem_addr_q   <= pc_start_i;
            halted_q     <= 1'b0;
            illegal_q    <= 1'b0;
            illegal_pc_q <= '0;
          end
        end
        S_FETCH: begin
          mem_rd_q <= 1'b0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // HALT (0x00) is tested first: it is neither legal nor an error.
          if (opc == OP_HALT) begin
            state_q  <= S_HALTED;
            halted_q <= 1'b1;
          end else if (dec_legal) begin
            state_q       <= S_ISSUE;
            out_valid_q   <= 1'b1;
            out_op_q      <= dec_op;
            out_imm_q     <= dec_imm;
            out_carry_q   <= dec_carry;
            out_operand_q <= bus.mem_rdata[DATA_W-1:0];
          end else begin
            state_q      <= S_ERROR;
            illegal_q    <= 1'b1;
            illegal_pc_q <= pc_q;
          end
        end
        S_ISSUE: begin
          // Fetch of the next word is launched in the same edge as the transfer.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_d;
            mem_rd_q    <= 1'b1;
            mem_addr_q  <= pc_d;
            state_q     <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd        = mem_rd_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_op        = out_op_q;
  assign bus.out_use_imm   = out_imm_q;
  assign bus.out_use_carry = out_carry_q;
  assign bus.out_operand   = out_operand_q;
  assign busy_o            = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_ISSUE);
  assign halted_o          = halted_q;
  assign illegal_o         = illegal_q;
  assign illegal_pc_o      = illegal_pc_q;

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Bench for cpu_fetch_decode: synchronous program memory model, opcode table, directed corner cases,
// and random programs compared against a program-walking reference model.
module tb_cpu_fetch_decode;
  import cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i = 1'b0;
  logic [7:0] pc_start_i = 8'h00;
  logic       busy_o, halted_o, illegal_o;
  logic [7:0] illegal_pc_o;

  cpu_fetch_decode_if #(.DATA_W(8), .ADDR_W(8)) bus ();

  cpu_fetch_decode #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .pc_start_i   (pc_start_i),
    .bus          (bus),
    .busy_o       (busy_o),
    .halted_o     (halted_o),
    .illegal_o    (illegal_o),
    .illegal_pc_o (illegal_pc_o)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  initial bus.mem_rdata = 16'h0000;
  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] pack(input Operation op, input logic imm, input logic c, input logic [7:0] d);
    return {3'b000, op, imm, c, d};
  endfunction

  function automatic logic [15:0] cur_out();
    return {3'b000, bus.out_op, bus.out_use_imm, bus.out_use_carry, bus.out_operand};
  endfunction

  // Reference model: walks the program as the ISA describes it, no notion of cycles.
  function automatic bit is_legal(input logic [7:0] o);
    int grp = int'(o) / 64;
    int mid = (int'(o) / 8) % 8;
    return (grp == 1 || grp == 2) && mid == 0;
  endfunction

  function automatic logic [15:0] model_word(input logic [7:0] o, input logic [7:0] d);
    Operation logic_ops [4];
    int v = int'(o);
    logic_ops = '{Operation_NOR, Operation_NAND, Operation_XOR, Operation_XNOR};
    if (v / 64 == 1)
      return pack((v % 2 == 1) ? Operation_SUB : Operation_ADD, 1'((v / 4) % 2), 1'((v / 2) % 2), d);
    return pack(logic_ops[v % 4], 1'((v / 4) % 2), 1'b0, d);
  endfunction

  logic [15:0] exp_q [$];
  logic        exp_halt, exp_ill;
  logic [7:0]  exp_ill_pc;

  task automatic model_run(input logic [7:0] pcs);
    logic [7:0] pc = pcs;
    bit done = 0;
    exp_q.delete();
    exp_halt = 0; exp_ill = 0; exp_ill_pc = 8'h00;
    for (int k = 0; k < 512 && !done; k++) begin
      if (mem[pc][15:8] == 8'h00) begin
        exp_halt = 1; done = 1;
      end else if (!is_legal(mem[pc][15:8])) begin
        exp_ill = 1; exp_ill_pc = pc; done = 1;
      end else begin
        exp_q.push_back(model_word(mem[pc][15:8], mem[pc][7:0]));
        pc = pc + 8'd1;
      end
    end
  endtask

  logic [15:0] got [$];
  logic [7:0]  fetches [$];
  int          stab_err;

  // Called at a negedge. Pulses start, then plays ALU with random readiness until idle.
  task automatic run(input logic [7:0] pcs, input int rdy_pct, input int max_cyc);
    int cyc = 0;
    logic pv = 0, pr = 0;
    logic [15:0] pw = 16'h0, cw;
    got.delete(); fetches.delete(); stab_err = 0;
    start_i = 1; pc_start_i = pcs;
    @(negedge clk);
    start_i = 0;
    while (busy_o && cyc < max_cyc) begin
      if (bus.mem_rd) fetches.push_back(bus.mem_addr);
      cw = cur_out();
      if (pv && !pr && (!bus.out_valid || cw != pw)) stab_err++;
      bus.out_ready = ($urandom_range(0, 99) < rdy_pct);
      if (bus.out_valid && bus.out_ready) got.push_back(cw);
      pv = bus.out_valid; pr = bus.out_ready; pw = cw;
      @(negedge clk);
      cyc++;
    end
    check("run_finished_in_budget", 32'(cyc < max_cyc), 32'd1);
    bus.out_ready = 0;
  endtask

  task automatic compare_model(input string tag, input logic [7:0] pcs);
    model_run(pcs);
    check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check({tag, "_instr"}, 32'(got[i]), 32'(exp_q[i]));
    check({tag, "_halted"}, 32'(halted_o), 32'(exp_halt));
    check({tag, "_illegal"}, 32'(illegal_o), 32'(exp_ill));
    check({tag, "_illegal_pc"}, 32'(illegal_pc_o), 32'(exp_ill_pc));
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic fill_mem(input logic [15:0] w);
    for (int i = 0; i < 256; i++) mem[i] = w;
  endtask

  typedef struct {
    logic [7:0] opc;
    logic [7:0] opd;
    int         kind;   // 0 issue, 1 halt, 2 illegal
    Operation   op;
    logic       imm;
    logic       carry;
  } vec_t;

  vec_t vt [12];
  int   n_legal, n_halt, n_ill, cnt, xfers;
  logic [15:0] w0;

  initial begin
    vt[0]  = '{8'h40, 8'h11, 0, Operation_ADD,  1'b0, 1'b0};
    vt[1]  = '{8'h41, 8'h22, 0, Operation_SUB,  1'b0, 1'b0};
    vt[2]  = '{8'h42, 8'h33, 0, Operation_ADD,  1'b0, 1'b1};
    vt[3]  = '{8'h45, 8'h44, 0, Operation_SUB,  1'b1, 1'b0};
    vt[4]  = '{8'h47, 8'h55, 0, Operation_SUB,  1'b1, 1'b1};
    vt[5]  = '{8'h81, 8'h66, 0, Operation_NAND, 1'b0, 1'b0};
    vt[6]  = '{8'h83, 8'h77, 0, Operation_XNOR, 1'b0, 1'b0};
    vt[7]  = '{8'h84, 8'h88, 0, Operation_NOR,  1'b1, 1'b0};
    vt[8]  = '{8'h00, 8'h99, 1, Operation_ADD,  1'b0, 1'b0};
    vt[9]  = '{8'h48, 8'hAA, 2, Operation_ADD,  1'b0, 1'b0};
    vt[10] = '{8'hC0, 8'hBB, 2, Operation_ADD,  1'b0, 1'b0};
    vt[11] = '{8'h88, 8'hCC, 2, Operation_ADD,  1'b0, 1'b0};

    bus.out_ready = 0;
    fill_mem(16'hFF00);
    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_mem_rd", 32'(bus.mem_rd), 32'd0);
    check("reset_op", 32'(bus.out_op), 32'(Operation_ADD));
    check("reset_busy", 32'(busy_o), 32'd0);
    rst_n = 1;
    @(negedge clk);
    check("idle_busy", 32'(busy_o), 32'd0);

    // Opcode table
    foreach (vt[i]) begin
      mem[8'h50] = {vt[i].opc, vt[i].opd};
      mem[8'h51] = 16'h0000;
      run(8'h50, 70, 200);
      if (vt[i].kind == 0) begin
        check("tbl_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) check("tbl_instr", 32'(got[0]), 32'(pack(vt[i].op, vt[i].imm, vt[i].carry, vt[i].opd)));
        check("tbl_halted", 32'(halted_o), 32'd1);
      end else begin
        check("tbl_count", 32'(got.size()), 32'd0);
        check("tbl_halted", 32'(halted_o), 32'(vt[i].kind == 1));
        check("tbl_illegal", 32'(illegal_o), 32'(vt[i].kind == 2));
        if (vt[i].kind == 2) check("tbl_illegal_pc", 32'(illegal_pc_o), 32'h50);
      end
    end

    // Three-word program, ALU always ready
    mem[0] = 16'h4005; mem[1] = 16'h863C; mem[2] = 16'h0000;
    run(8'h00, 100, 100);
    check("prog_count", 32'(got.size()), 32'd2);
    if (got.size() > 1) begin
      check("prog_i0", 32'(got[0]), 32'(pack(Operation_ADD, 1'b0, 1'b0, 8'h05)));
      check("prog_i1", 32'(got[1]), 32'(pack(Operation_XOR, 1'b1, 1'b0, 8'h3C)));
    end
    check("prog_halted", 32'(halted_o), 32'd1);
    check("prog_busy", 32'(busy_o), 32'd0);

    // Backpressure: hold for 5 cycles, exactly one transfer
    mem[8'h30] = 16'h47FF; mem[8'h31] = 16'h0000;
    bus.out_ready = 0; start_i = 1; pc_start_i = 8'h30;
    @(negedge clk); start_i = 0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("bp_valid_rose", 32'(bus.out_valid), 32'd1);
    check("bp_latency", 32'(cnt), 32'd2);
    w0 = cur_out();
    check("bp_word", 32'(w0), 32'(pack(Operation_SUB, 1'b1, 1'b1, 8'hFF)));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      check("bp_hold_dat", 32'(cur_out()), 32'(w0));
    end
    bus.out_ready = 1;
    @(negedge clk);
    check("bp_valid_dropped", 32'(bus.out_valid), 32'd0);
    xfers = 0; cnt = 0;
    while (busy_o && cnt < 20) begin
      if (bus.out_valid) xfers++;
      @(negedge clk); cnt++;
    end
    check("bp_extra_xfers", 32'(xfers), 32'd0);
    check("bp_halted", 32'(halted_o), 32'd1);

    // Illegal opcode, then start clears it
    mem[8'h10] = 16'h4812;
    run(8'h10, 100, 100);
    check("ill_count", 32'(got.size()), 32'd0);
    check("ill_flag", 32'(illegal_o), 32'd1);
    check("ill_pc", 32'(illegal_pc_o), 32'h10);
    mem[8'h60] = 16'h0000;
    start_i = 1; pc_start_i = 8'h60;
    @(negedge clk); start_i = 0;
    check("ill_cleared", 32'(illegal_o), 32'd0);
    check("ill_pc_cleared", 32'(illegal_pc_o), 32'd0);
    repeat (4) @(negedge clk);

    // PC wrap
    mem[8'hFF] = 16'h8000; mem[8'h00] = 16'h0000;
    run(8'hFF, 100, 100);
    check("wrap_count", 32'(got.size()), 32'd1);
    if (got.size() > 0) check("wrap_instr", 32'(got[0]), 32'(pack(Operation_NOR, 1'b0, 1'b0, 8'h00)));
    check("wrap_fetches", 32'(fetches.size()), 32'd2);
    if (fetches.size() > 1) begin
      check("wrap_fetch0", 32'(fetches[0]), 32'hFF);
      check("wrap_fetch1", 32'(fetches[1]), 32'h00);
    end
    check("wrap_halted", 32'(halted_o), 32'd1);

    // Reset while an instruction is offered
    mem[8'h40] = 16'h8155; mem[8'h41] = 16'h0000;
    bus.out_ready = 0; start_i = 1; pc_start_i = 8'h40;
    @(negedge clk); start_i = 0;
    cnt = 0;
    while (!bus.out_valid && cnt < 20) begin @(negedge clk); cnt++; end
    check("rst_pre_valid", 32'(bus.out_valid), 32'd1);
    #2 rst_n = 0;
    #1;
    check("rst_async_valid", 32'(bus.out_valid), 32'd0);
    check("rst_async_busy", 32'(busy_o), 32'd0);
    check("rst_async_op", 32'(bus.out_op), 32'(Operation_ADD));
    check("rst_async_operand", 32'(bus.out_operand), 32'd0);
    @(negedge clk);
    rst_n = 1; bus.out_ready = 1;
    xfers = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid || busy_o) xfers++;
      @(negedge clk);
    end
    check("rst_stays_idle", 32'(xfers), 32'd0);
    bus.out_ready = 0;

    // Opcode sweep
    n_legal = 0; n_halt = 0; n_ill = 0;
    for (int o = 0; o < 256; o++) begin
      mem[8'h20] = {8'(o), 8'hA5};
      mem[8'h21] = 16'h0000;
      run(8'h20, 100, 60);
      compare_model("sweep", 8'h20);
      if (got.size() == 1) n_legal++;
      else if (halted_o) n_halt++;
      else if (illegal_o) n_ill++;
    end
    check("sweep_legal", 32'(n_legal), 32'd16);
    check("sweep_halt", 32'(n_halt), 32'd1);
    check("sweep_illegal", 32'(n_ill), 32'd239);

    // Random programs
    for (int r = 0; r < 40; r++) begin
      logic [7:0] pcs, opc;
      int sel;
      for (int i = 0; i < 256; i++) begin
        sel = $urandom_range(0, 99);
        if (sel < 70) opc = {($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10, 3'b000, 3'($urandom_range(0, 7))};
        else if (sel < 78) opc = 8'h00;
        else opc = 8'($urandom_range(0, 255));
        if (opc[7:6] == 2'b10) opc[2] = opc[2];
        mem[i] = {opc, 8'($urandom_range(0, 255))};
      end
      pcs = 8'($urandom_range(0, 255));
      mem[pcs + 8'd12] = 16'h0000;
      run(pcs, $urandom_range(30, 100), 4000);
      compare_model("rand", pcs);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
